// File: rtl/operand_issue_if.sv
// Handshake, operand and writeback bundle between the decode stage, the operand_issue
// stage and the ALU. The slave modport is the issue stage's view; master is the driver's view.
interface operand_issue_if #(
   parameter int BUS_WIDTH  = 32,
   parameter int ADDR_WIDTH = 5
);
   logic                  in_valid;
   logic                  in_ready;
   logic [ADDR_WIDTH-1:0] rs;
   logic [ADDR_WIDTH-1:0] rt;
   logic [ADDR_WIDTH-1:0] rd;
   logic                  op_sub;

   logic                  out_valid;
   logic                  out_ready;
   logic [BUS_WIDTH-1:0]  A;
   logic [BUS_WIDTH-1:0]  B;
   logic                  sub;
   logic [ADDR_WIDTH-1:0] out_rd;

   logic                  wb_en;
   logic [ADDR_WIDTH-1:0] wb_addr;
   logic [BUS_WIDTH-1:0]  wb_data;

   modport slave (
      input  in_valid, rs, rt, rd, op_sub, out_ready, wb_en, wb_addr, wb_data,
      output in_ready, out_valid, A, B, sub, out_rd
   );

   modport master (
      output in_valid, rs, rt, rd, op_sub, out_ready, wb_en, wb_addr, wb_data,
      input  in_ready, out_valid, A, B, sub, out_rd
   );
endinterface

// File: rtl/operand_issue.sv
// Operand-fetch/issue stage: register file, busy scoreboard, registered ALU operands.
// Define FORWARD_EN to bypass same-cycle writeback data into the issuing operands.
module operand_issue #(
   parameter int BUS_WIDTH  = 32,
   parameter int ADDR_WIDTH = 5
) (
   input  logic           clk,
   input  logic           rst_n,
   operand_issue_if.slave bus
);
   localparam int NREGS = 2 ** ADDR_WIDTH;

   logic [BUS_WIDTH-1:0]  rf_q [NREGS];
   logic [NREGS-1:0]      busy_q, busy_d;

   logic                  out_valid_q, out_valid_d;
   logic [BUS_WIDTH-1:0]  a_q, a_d;
   logic [BUS_WIDTH-1:0]  b_q, b_d;
   logic                  sub_q, sub_d;
   logic [ADDR_WIDTH-1:0] out_rd_q, out_rd_d;

   logic                  wb_live;
   logic                  fwd_rs, fwd_rt, fwd_rd;
   logic                  hz, in_ready, fire;

   // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
   always_comb begin
      wb_live = bus.wb_en && (bus.wb_addr != '0);
`ifdef FORWARD_EN
      fwd_rs = wb_live && (bus.wb_addr == bus.rs);
      fwd_rt = wb_live && (bus.wb_addr == bus.rt);
      fwd_rd = wb_live && (bus.wb_addr == bus.rd);
`else
      fwd_rs = 1'b0;
      fwd_rt = 1'b0;
      fwd_rd = 1'b0;
`endif
      hz = (busy_q[bus.rs] && !fwd_rs) ||
           (busy_q[bus.rt] && !fwd_rt) ||
           (busy_q[bus.rd] && !fwd_rd);
      in_ready = !hz && (!out_valid_q || bus.out_ready);
      fire     = bus.in_valid && in_ready;

      if (bus.rs == '0)  a_d = '0;
      else if (fwd_rs)   a_d = bus.wb_data;
      else               a_d = rf_q[bus.rs];

      if (bus.rt == '0)  b_d = '0;
      else if (fwd_rt)   b_d = bus.wb_data;
      else               b_d = rf_q[bus.rt];

      sub_d    = bus.op_sub;
      out_rd_d = bus.rd;

      // Writeback clears first so a same-edge issue to the same index re-marks it busy.
      busy_d = busy_q;
      if (wb_live)                  busy_d[bus.wb_addr] = 1'b0;
      if (fire && bus.rd != '0)     busy_d[bus.rd]      = 1'b1;

      if (fire)               out_valid_d = 1'b1;
      else if (bus.out_ready) out_valid_d = 1'b0;
      else                    out_valid_d = out_valid_q;
   end

   // NOTE: the register file is reset like any other state, so no stale value survives rst_n.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
      end else if (wb_live) begin
         rf_q[bus.wb_addr] <= bus.wb_data;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q      <= '0;
         out_valid_q <= 1'b0;
         a_q         <= '0;
         b_q         <= '0;
         sub_q       <= 1'b0;
         out_rd_q    <= '0;
      end else begin
         busy_q      <= busy_d;
         out_valid_q <= out_valid_d;
         if (fire) begin
            a_q      <= a_d;
            b_q      <= b_d;
            sub_q    <= sub_d;
            out_rd_q <= out_rd_d;
         end
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.A         = a_q;
   assign bus.B         = b_q;
   assign bus.sub       = sub_q;
   assign bus.out_rd    = out_rd_q;

endmodule

// File: tb/tb_operand_issue.sv
// Directed bench for operand_issue: issue, RAW stall, r0, backpressure, same-edge set/clear, reset.
module tb_operand_issue;
   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_fail;

   operand_issue_if #(.BUS_WIDTH(32), .ADDR_WIDTH(5)) bus ();

   operand_issue #(.BUS_WIDTH(32), .ADDR_WIDTH(5)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance one clock; inputs change and outputs are sampled 1 ns after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic op_sub);
      bus.in_valid = v;
      bus.rs       = rs;
      bus.rt       = rt;
      bus.rd       = rd;
      bus.op_sub   = op_sub;
   endtask

   task automatic set_wb(input logic en, input logic [4:0] addr, input logic [31:0] data);
      bus.wb_en   = en;
      bus.wb_addr = addr;
      bus.wb_data = data;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst_n    = 1'b0;
      bus.out_ready = 1'b1;
      set_op(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
      set_wb(1'b0, 5'd0, 32'd0);
      tick();
      tick();

      // Reset state
      check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      check("rst_A", bus.A, 32'd0);
      check("rst_B", bus.B, 32'd0);
      check("rst_sub", {31'd0, bus.sub}, 32'd0);
      check("rst_out_rd", {27'd0, bus.out_rd}, 32'd0);
      check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
      rst_n = 1'b1;
      tick();

      // Basic issue: r1=7, r2=3, sub r3 = r1 - r2
      set_wb(1'b1, 5'd1, 32'd7);
      tick();
      set_wb(1'b1, 5'd2, 32'd3);
      tick();
      set_wb(1'b0, 5'd0, 32'd0);
      set_op(1'b1, 5'd1, 5'd2, 5'd3, 1'b1);
      #1;
      check("t2_in_ready", {31'd0, bus.in_ready}, 32'd1);
      tick();
      set_op(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
      check("t2_out_valid", {31'd0, bus.out_valid}, 32'd1);
      check("t2_A", bus.A, 32'd7);
      check("t2_B", bus.B, 32'd3);
      check("t2_sub", {31'd0, bus.sub}, 32'd1);
      check("t2_out_rd", {27'd0, bus.out_rd}, 32'd3);

      // RAW on r3
      set_op(1'b1, 5'd3, 5'd1, 5'd5, 1'b0);
      #1;
      check("t3_stall0", {31'd0, bus.in_ready}, 32'd0);
      tick();
      check("t3_drained", {31'd0, bus.out_valid}, 32'd0);
      check("t3_stall1", {31'd0, bus.in_ready}, 32'd0);
      set_wb(1'b1, 5'd3, 32'd4);
      #1;
`ifdef FORWARD_EN
      check("t3_fwd_ready", {31'd0, bus.in_ready}, 32'd1);
      tick();
      set_wb(1'b0, 5'd0, 32'd0);
`else
      check("t3_wb_cycle_stall", {31'd0, bus.in_ready}, 32'd0);
      tick();
      set_wb(1'b0, 5'd0, 32'd0);
      #1;
      check("t3_bubble_valid", {31'd0, bus.out_valid}, 32'd0);
      check("t3_ready_after_wb", {31'd0, bus.in_ready}, 32'd1);
      tick();
`endif
      set_op(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
      check("t3_out_valid", {31'd0, bus.out_valid}, 32'd1);
      check("t3_A", bus.A, 32'd4);
      check("t3_B", bus.B, 32'd7);
      check("t3_out_rd", {27'd0, bus.out_rd}, 32'd5);
      set_wb(1'b1, 5'd5, 32'h55);
      tick();
      set_wb(1'b0, 5'd0, 32'd0);

      // r0: writes ignored, never busy, back-to-back issue
      set_wb(1'b1, 5'd0, 32'd9);
      tick();
      set_wb(1'b0, 5'd0, 32'd0);
      set_op(1'b1, 5'd0, 5'd0, 5'd0, 1'b0);
      #1;
      check("t4_ready", {31'd0, bus.in_ready}, 32'd1);
      tick();
      check("t4_A_r0", bus.A, 32'd0);
      set_op(1'b1, 5'd0, 5'd1, 5'd6, 1'b0);
      #1;
      check("t4_r0_no_stall", {31'd0, bus.in_ready}, 32'd1);
      tick();
      check("t4_b2b_valid", {31'd0, bus.out_valid}, 32'd1);
      check("t4_b2b_A", bus.A, 32'd0);
      check("t4_b2b_B", bus.B, 32'd7);
      check("t4_b2b_rd", {27'd0, bus.out_rd}, 32'd6);

      // Backpressure: hold the r6 op for three cycles
      bus.out_ready = 1'b0;
      set_op(1'b1, 5'd1, 5'd2, 5'd7, 1'b1);
      for (int i = 0; i < 3; i++) begin
         #1;
         check("t5_stall_ready", {31'd0, bus.in_ready}, 32'd0);
         tick();
         check("t5_hold_valid", {31'd0, bus.out_valid}, 32'd1);
         check("t5_hold_B", bus.B, 32'd7);
         check("t5_hold_rd", {27'd0, bus.out_rd}, 32'd6);
         check("t5_hold_sub", {31'd0, bus.sub}, 32'd0);
      end
      bus.out_ready = 1'b1;
      #1;
      check("t5_release_ready", {31'd0, bus.in_ready}, 32'd1);
      tick();
      set_op(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
      check("t5_next_A", bus.A, 32'd7);
      check("t5_next_B", bus.B, 32'd3);
      check("t5_next_sub", {31'd0, bus.sub}, 32'd1);
      check("t5_next_rd", {27'd0, bus.out_rd}, 32'd7);
      tick();
      check("t5_drain", {31'd0, bus.out_valid}, 32'd0);

      // Same-edge writeback clear and issue set on r4: set wins
      set_wb(1'b1, 5'd4, 32'h44);
      set_op(1'b1, 5'd1, 5'd2, 5'd4, 1'b0);
      #1;
      check("t6_fire", {31'd0, bus.in_ready}, 32'd1);
      tick();
      set_wb(1'b0, 5'd0, 32'd0);
      set_op(1'b1, 5'd4, 5'd0, 5'd0, 1'b0);
      #1;
      check("t6_r4_busy", {31'd0, bus.in_ready}, 32'd0);
      tick();
      check("t6_r4_still_busy", {31'd0, bus.in_ready}, 32'd0);
      set_wb(1'b1, 5'd4, 32'h99);
      tick();
      set_wb(1'b0, 5'd0, 32'd0);
      #1;
      check("t6_ready_after_wb", {31'd0, bus.in_ready}, 32'd1);
      tick();
      set_op(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
      check("t6_A", bus.A, 32'h99);

      // Reset mid-stall: r7 busy (from backpressure test) and output held
      bus.out_ready = 1'b0;
      set_op(1'b1, 5'd1, 5'd1, 5'd8, 1'b1);
      tick();
      set_op(1'b1, 5'd1, 5'd1, 5'd9, 1'b1);
      check("t1_pre_valid", {31'd0, bus.out_valid}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("t1_async_valid", {31'd0, bus.out_valid}, 32'd0);
      check("t1_async_A", bus.A, 32'd0);
      check("t1_async_B", bus.B, 32'd0);
      set_op(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
      bus.out_ready = 1'b1;
      tick();
      rst_n = 1'b1;
      set_op(1'b1, 5'd5, 5'd7, 5'd7, 1'b0);
      #1;
      check("t1_busy_cleared", {31'd0, bus.in_ready}, 32'd1);
      tick();
      set_op(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
      check("t1_r5_zero", bus.A, 32'd0);
      check("t1_r7_zero", bus.B, 32'd0);
      check("t1_valid", {31'd0, bus.out_valid}, 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
